// File: rtl/powermanager_pkg.sv
// Shared types and constants for the power-rail sequencer.
// Holds the state encoding that is also exported on state_out.
package powermanager_pkg;

    localparam int PM_STATE_W   = 3;
    localparam int PM_MAX_RAILS = 8;

    typedef enum logic [PM_STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_ON       = 3'd2,
        ST_PWR_DOWN = 3'd3,
        ST_OFF_WAIT = 3'd4,
        ST_FAULT    = 3'd5
    } pm_state_t;

endpackage

// File: rtl/powermanager_sequencer_if.sv
// Command/config/status bundle between register bank and sequencer.
// master: register bank + comparator side; slave: the sequencer.
interface powermanager_sequencer_if #(
    parameter int NUM_RAILS = 4,
    parameter int CNT_WIDTH = 24
);
    import powermanager_pkg::*;

    logic                  cmd_on;
    logic                  cmd_off;
    logic                  cmd_cycle;
    logic                  fault_clear;
    logic [NUM_RAILS-1:0]  rail_mask;
    logic [CNT_WIDTH-1:0]  step_delay;
    logic [CNT_WIDTH-1:0]  off_time;
    logic                  oc_in;
    logic [NUM_RAILS-1:0]  rail_en;
    logic [PM_STATE_W-1:0] state_out;
    logic                  busy;
    logic                  fault;
    logic                  done;

    modport master (
        output cmd_on, cmd_off, cmd_cycle, fault_clear,
        output rail_mask, step_delay, off_time, oc_in,
        input  rail_en, state_out, busy, fault, done
    );

    modport slave (
        input  cmd_on, cmd_off, cmd_cycle, fault_clear,
        input  rail_mask, step_delay, off_time, oc_in,
        output rail_en, state_out, busy, fault, done
    );

endinterface

// File: rtl/pm_delay_counter.sv
// Step/hold delay counter: load starts a count 1..target (0 as 1).
// Ports: clk, rst, load, clear, target in; expired pulse, running out.
module pm_delay_counter #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] target,
    output logic                 expired,
    output logic                 running
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] tgt_q, tgt_d;
    logic                 run_q, run_d;

    assign expired = run_q && (cnt_q == tgt_q);
    assign running = run_q;

    always_comb begin
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        run_d = run_q;
        if (load) begin
            cnt_d = CNT_WIDTH'(1);
            tgt_d = (target == '0) ? CNT_WIDTH'(1) : target;
            run_d = 1'b1;
        end else if (clear || expired) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tgt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/powermanager_sequencer.sv
// Ordered, time-spaced rail enable sequencing with overcurrent trip.
// Ports: ACLK, ARESET (sync, high), pm (slave bundle of cmds/status).
module powermanager_sequencer
    import powermanager_pkg::*;
#(
    parameter int NUM_RAILS = 4,
    parameter int CNT_WIDTH = 24,
    parameter int OC_FILTER = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    powermanager_sequencer_if.slave pm
);
    localparam int RAILS = (NUM_RAILS > PM_MAX_RAILS) ? PM_MAX_RAILS : NUM_RAILS;
    localparam int IDX_W = (RAILS > 1) ? $clog2(RAILS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(RAILS - 1);
    localparam logic [3:0] OC_LIM = 4'(OC_FILTER);

    pm_state_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_up, idx_dn;
    logic [NUM_RAILS-1:0] mask_q, mask_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 cycle_q, cycle_d;
    logic                 done_q, done_d;
    logic [3:0]           oc_cnt_q, oc_cnt_d;
    logic                 oc_qual, oc_trip;
    logic                 load, cnt_clear, cnt_expired, cnt_running;
    logic [CNT_WIDTH-1:0] load_tgt;

    pm_delay_counter #(.CNT_WIDTH(CNT_WIDTH)) u_delay (
        .clk    (ACLK),
        .rst    (ARESET),
        .load   (load),
        .clear  (cnt_clear),
        .target (load_tgt),
        .expired(cnt_expired),
        .running(cnt_running)
    );

    // Filter only counts while something is actually powered.
    always_comb begin
        oc_qual = pm.oc_in && (|rail_en_q);
        if (!oc_qual)
            oc_cnt_d = '0;
        else if (oc_cnt_q != OC_LIM)
            oc_cnt_d = oc_cnt_q + 4'd1;
        else
            oc_cnt_d = oc_cnt_q;
        oc_trip = oc_qual && (oc_cnt_d == OC_LIM);
    end

    // A step is "pending" when the counter is idle: the index is
    // examined on the next edge. A finished step starts the next
    // enabled index on the same edge so rails land D cycles apart.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        rail_en_d = rail_en_q;
        cycle_d   = cycle_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_tgt  = pm.step_delay;
        idx_up    = idx_q + IDX_W'(1);
        idx_dn    = idx_q - IDX_W'(1);
        case (state_q)
            ST_OFF: begin
                if (!pm.cmd_off && (pm.cmd_on || pm.cmd_cycle)) begin
                    mask_d  = pm.rail_mask;
                    idx_d   = '0;
                    cycle_d = 1'b0;
                    if (pm.rail_mask == '0) done_d = 1'b1;
                    else state_d = ST_PWR_UP;
                end
            end
            ST_PWR_UP: begin
                if (pm.cmd_off) begin
                    state_d = ST_PWR_DOWN;
                    idx_d   = LAST;
                end else if (!cnt_running && mask_q[idx_q]) begin
                    rail_en_d[idx_q] = 1'b1;
                    load = 1'b1;
                end else if (!cnt_running || cnt_expired) begin
                    if (idx_q == LAST) begin
                        state_d = ST_ON;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_up;
                        if (mask_q[idx_up]) begin
                            rail_en_d[idx_up] = 1'b1;
                            load = 1'b1;
                        end
                    end
                end
            end
            ST_ON: begin
                if (pm.cmd_off || pm.cmd_cycle) begin
                    state_d = ST_PWR_DOWN;
                    idx_d   = LAST;
                    cycle_d = !pm.cmd_off;
                end
            end
            ST_PWR_DOWN: begin
                if (!cnt_running && rail_en_q[idx_q]) begin
                    rail_en_d[idx_q] = 1'b0;
                    load = 1'b1;
                end else if (!cnt_running || cnt_expired) begin
                    if (idx_q == '0) begin
                        if (cycle_q) begin
                            state_d  = ST_OFF_WAIT;
                            load     = 1'b1;
                            load_tgt = pm.off_time;
                        end else begin
                            state_d = ST_OFF;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_dn;
                        if (rail_en_q[idx_dn]) begin
                            rail_en_d[idx_dn] = 1'b0;
                            load = 1'b1;
                        end
                    end
                end
            end
            ST_OFF_WAIT: begin
                if (pm.cmd_off) begin
                    state_d = ST_OFF;
                    cycle_d = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_expired) begin
                    state_d = ST_PWR_UP;
                    mask_d  = pm.rail_mask;
                    idx_d   = '0;
                    cycle_d = 1'b0;
                end
            end
            ST_FAULT: begin
                if (pm.fault_clear && !pm.oc_in) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
        if (oc_trip) begin
            state_d   = ST_FAULT;
            rail_en_d = '0;
            idx_d     = '0;
            cycle_d   = 1'b0;
            done_d    = 1'b0;
            load      = 1'b0;
        end
        cnt_clear = !load && (state_d != state_q);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_OFF;
            idx_q     <= '0;
            mask_q    <= '0;
            rail_en_q <= '0;
            cycle_q   <= 1'b0;
            done_q    <= 1'b0;
            oc_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            rail_en_q <= rail_en_d;
            cycle_q   <= cycle_d;
            done_q    <= done_d;
            oc_cnt_q  <= oc_cnt_d;
        end
    end

    assign pm.rail_en   = rail_en_q;
    assign pm.state_out = state_q;
    assign pm.busy      = (state_q == ST_PWR_UP) || (state_q == ST_PWR_DOWN)
                       || (state_q == ST_OFF_WAIT);
    assign pm.fault     = (state_q == ST_FAULT);
    assign pm.done      = done_q;

endmodule

// File: tb/tb_powermanager_sequencer.sv
// Directed bench for powermanager_sequencer: rail-change scoreboard
// plus cycle-exact state/done checks.
module tb_powermanager_sequencer;
    import powermanager_pkg::*;

    localparam int NR = 4;
    localparam int CW = 24;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } ev_t;

    logic ACLK = 1'b0;
    logic ARESET;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   exp_done = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev_rail = 4'h0;
    ev_t  exp_q[$];
    ev_t  mon_ev;
    int   t;
    int   u;

    powermanager_sequencer_if #(.NUM_RAILS(NR), .CNT_WIDTH(CW)) pm ();

    powermanager_sequencer #(
        .NUM_RAILS(NR),
        .CNT_WIDTH(CW),
        .OC_FILTER(4)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .pm    (pm.slave)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc++;

    // Every rail_en change must match the next queued (value, edge).
    always @(negedge ACLK) begin
        if (pm.done === 1'b1) n_done++;
        if (mon_en && (pm.rail_en !== prev_rail)) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL sb_extra observed=%0h@%0d expected=none",
                       pm.rail_en, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                assert (pm.rail_en === mon_ev.val && cyc === mon_ev.cyc)
                else begin
                    n_fail++;
                    $error("FAIL sb_event observed=%0h@%0d expected=%0h@%0d",
                           pm.rail_en, cyc, mon_ev.val, mon_ev.cyc);
                end
            end
        end
        prev_rail = pm.rail_en;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] v, input int c);
        ev_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // 0=on 1=off 2=cycle 3=fault_clear; returns just after the sampling edge
    task automatic pulse_cmd(input int which);
        case (which)
            0: pm.cmd_on = 1'b1;
            1: pm.cmd_off = 1'b1;
            2: pm.cmd_cycle = 1'b1;
            default: pm.fault_clear = 1'b1;
        endcase
        tick();
        pm.cmd_on      = 1'b0;
        pm.cmd_off     = 1'b0;
        pm.cmd_cycle   = 1'b0;
        pm.fault_clear = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int lim,
                              input string tag);
        int n = 0;
        while (pm.state_out !== st && n < lim) begin
            tick();
            n++;
        end
        chk(tag, pm.state_out, st);
    endtask

    // Full-mask up/down sequences with uniform step D from edge t0.
    task automatic push_up_full(input int t0, input int d);
        for (int k = 0; k < 4; k++)
            push(4'((5'd1 << (k + 1)) - 5'd1), t0 + 1 + k * d);
    endtask

    task automatic push_dn_full(input int t0, input int d);
        for (int k = 0; k < 4; k++)
            push(4'(4'hF >> (k + 1)), t0 + 1 + k * d);
    endtask

    initial begin
        ARESET         = 1'b1;
        pm.cmd_on      = 1'b0;
        pm.cmd_off     = 1'b0;
        pm.cmd_cycle   = 1'b0;
        pm.fault_clear = 1'b0;
        pm.rail_mask   = 4'hF;
        pm.step_delay  = 24'd10;
        pm.off_time    = 24'd1;
        pm.oc_in       = 1'b0;
        tick(3);
        chk("rst_rail", pm.rail_en, 0);
        chk("rst_state", pm.state_out, ST_OFF);
        chk("rst_busy", pm.busy, 0);
        chk("rst_fault", pm.fault, 0);
        chk("rst_done", pm.done, 0);
        ARESET = 1'b0;
        mon_en = 1'b1;
        tick();

        // Full power-up, D=10
        pulse_cmd(0);
        t = cyc;
        push_up_full(t, 10);
        for (int k = 0; k <= 41; k++) begin
            chk("up_busy", pm.busy, (k <= 40));
            chk("up_state", pm.state_out, (k <= 40) ? ST_PWR_UP : ST_ON);
            chk("up_done", pm.done, (k == 41));
            if (k < 41) tick();
        end
        chk("up_rail", pm.rail_en, 4'hF);
        exp_done++;

        // Full power-down, reverse order
        pulse_cmd(1);
        t = cyc;
        push_dn_full(t, 10);
        wait_state(ST_OFF, 60, "dn_off");
        chk("dn_cyc", cyc, t + 41);
        exp_done++;
        tick();
        chk("dn_done_cnt", n_done, exp_done);

        // Sparse mask 0101, D=5: a skipped index costs one cycle
        pm.rail_mask  = 4'b0101;
        pm.step_delay = 24'd5;
        pulse_cmd(0);
        t = cyc;
        push(4'b0001, t + 1);
        push(4'b0101, t + 7);
        wait_state(ST_ON, 30, "sp_on");
        chk("sp_on_cyc", cyc, t + 13);
        exp_done++;
        pulse_cmd(1);
        t = cyc;
        push(4'b0001, t + 1);
        push(4'b0000, t + 7);
        wait_state(ST_OFF, 30, "sp_off");
        chk("sp_off_cyc", cyc, t + 12);
        exp_done++;
        tick();
        chk("sp_done_cnt", n_done, exp_done);

        // Power cycle: D=2, off_time=20
        pm.rail_mask  = 4'hF;
        pm.step_delay = 24'd2;
        pulse_cmd(0);
        t = cyc;
        push_up_full(t, 2);
        wait_state(ST_ON, 20, "pc_on");
        chk("pc_on_cyc", cyc, t + 9);
        exp_done++;
        pm.off_time = 24'd20;
        pulse_cmd(2);
        u = cyc;
        push_dn_full(u, 2);
        push_up_full(u + 29, 2);
        wait_state(ST_OFF_WAIT, 20, "pc_wait");
        chk("pc_wait_cyc", cyc, u + 9);
        chk("pc_wait_rail", pm.rail_en, 0);
        chk("pc_wait_busy", pm.busy, 1);
        wait_state(ST_PWR_UP, 30, "pc_reup");
        chk("pc_reup_cyc", cyc, u + 29);
        wait_state(ST_ON, 20, "pc_on2");
        chk("pc_on2_cyc", cyc, u + 38);
        exp_done++;
        tick();
        chk("pc_done_cnt", n_done, exp_done);

        // Overcurrent: 3 cycles is filtered out, 4 trips
        pm.oc_in = 1'b1;
        tick(3);
        pm.oc_in = 1'b0;
        tick(2);
        chk("oc3_fault", pm.fault, 0);
        chk("oc3_rail", pm.rail_en, 4'hF);
        pm.oc_in = 1'b1;
        tick(3);
        chk("oc_pre_fault", pm.fault, 0);
        push(4'h0, cyc + 1);
        tick();
        chk("oc_fault", pm.fault, 1);
        chk("oc_state", pm.state_out, ST_FAULT);
        chk("oc_rail", pm.rail_en, 0);
        pulse_cmd(3);
        chk("oc_clr_held", pm.state_out, ST_FAULT);
        pulse_cmd(0);
        chk("oc_cmd_ign", pm.state_out, ST_FAULT);
        pm.oc_in = 1'b0;
        pulse_cmd(3);
        chk("oc_clr_state", pm.state_out, ST_OFF);
        chk("oc_clr_fault", pm.fault, 0);
        tick();
        chk("oc_done_cnt", n_done, exp_done);

        // Same-cycle on+off in OFF: off wins, nothing happens
        pm.cmd_on  = 1'b1;
        pm.cmd_off = 1'b1;
        tick();
        pm.cmd_on  = 1'b0;
        pm.cmd_off = 1'b0;
        chk("pri_state", pm.state_out, ST_OFF);
        chk("pri_done", pm.done, 0);

        // Empty mask: stays OFF, done pulses
        pm.rail_mask = 4'h0;
        pulse_cmd(0);
        chk("m0_state", pm.state_out, ST_OFF);
        chk("m0_done", pm.done, 1);
        exp_done++;
        tick();
        chk("m0_done_cnt", n_done, exp_done);

        // Abort during power-up after two rails
        pm.rail_mask  = 4'hF;
        pm.step_delay = 24'd10;
        pulse_cmd(0);
        t = cyc;
        push(4'h1, t + 1);
        push(4'h3, t + 11);
        tick(15);
        pulse_cmd(1);
        u = cyc;
        push(4'h1, u + 2);
        push(4'h0, u + 12);
        chk("ab_state", pm.state_out, ST_PWR_DOWN);
        wait_state(ST_OFF, 40, "ab_off");
        chk("ab_cyc", cyc, u + 22);
        chk("ab_rail", pm.rail_en, 0);
        exp_done++;

        // Reset mid power-up
        pulse_cmd(0);
        t = cyc;
        push(4'h1, t + 1);
        push(4'h3, t + 11);
        tick(13);
        ARESET = 1'b1;
        push(4'h0, cyc + 1);
        tick();
        ARESET = 1'b0;
        chk("rs_rail", pm.rail_en, 0);
        chk("rs_state", pm.state_out, ST_OFF);
        chk("rs_busy", pm.busy, 0);
        pulse_cmd(0);
        t = cyc;
        push_up_full(t, 10);
        wait_state(ST_ON, 60, "rs_on");
        chk("rs_on_cyc", cyc, t + 41);
        exp_done++;

        // step_delay=0 behaves as 1
        pulse_cmd(1);
        t = cyc;
        push_dn_full(t, 10);
        wait_state(ST_OFF, 60, "z_off0");
        exp_done++;
        pm.step_delay = 24'd0;
        pulse_cmd(0);
        t = cyc;
        push_up_full(t, 1);
        wait_state(ST_ON, 20, "z_on");
        chk("z_on_cyc", cyc, t + 5);
        exp_done++;
        pulse_cmd(1);
        t = cyc;
        push_dn_full(t, 1);
        wait_state(ST_OFF, 20, "z_off");
        chk("z_off_cyc", cyc, t + 5);
        exp_done++;

        tick(2);
        chk("sb_empty", exp_q.size(), 0);
        chk("done_total", n_done, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
